// File: rtl/golay_pkg.sv
// Shared constants, types and helpers for the extended Golay(24,12) stream decoder.
// Vectors are row vectors whose element 0 sits in the MSB.
package golay_pkg;

  localparam int unsigned DW = 12;
  localparam int unsigned CW = 24;

  // Symmetric and self-inverse (B * B^T = I), so t = s * B needs no transpose.
  localparam logic [DW-1:0] GolayB [DW] = '{
    12'hDC5, 12'hB8B, 12'h717, 12'hE2D, 12'hC5B, 12'h8B7,
    12'h16F, 12'h2DD, 12'h5B9, 12'hB71, 12'h6E3, 12'hFFE
  };

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DW-1:0] parity;
    logic          good;
    logic          bad;
  } lane_res_t;

  function automatic logic [3:0] weight(input logic [DW-1:0] v);
    logic [3:0] w;
    w = '0;
    for (int unsigned i = 0; i < DW; i++) w = w + 4'(v[i]);
    return w;
  endfunction

  function automatic logic [DW-1:0] unit_vec(input int unsigned i);
    return {1'b1, {(DW-1){1'b0}}} >> i;
  endfunction

  // Vector-matrix product over GF(2).
  function automatic logic [DW-1:0] gmul(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (v[DW-1-i]) r = r ^ GolayB[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/golay_lane_dec.sv
// One lane: registers the received word, decodes it in a single comb step, then
// delays the result so the whole lane spans LAT register stages alongside its valid bit.
module golay_lane_dec
  import golay_pkg::*;
#(
  parameter int unsigned LAT = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           valid_i,
  input  logic           mode_i,
  input  logic [DW-1:0]  data_i,
  input  logic [DW-1:0]  parity_i,
  output logic [LAT-1:0] vld_o,
  output lane_res_t      res_o
);

  logic [DW-1:0]  data_q, data_d, par_q, par_d;
  logic           mode_q, mode_d;
  logic [LAT-1:0] vld_q, vld_d;
  lane_res_t      res_q [LAT-1];
  lane_res_t      res_d [LAT-1];

  logic [DW-1:0]  syn, tsyn, err_d, err_p;
  logic           found;
  lane_res_t      dec;

  always_comb begin
    syn   = par_q ^ gmul(data_q);
    tsyn  = gmul(syn);
    found = 1'b0;
    err_d = '0;
    err_p = '0;
    if (weight(syn) <= 4'd3) begin
      found = 1'b1;
      err_p = syn;
    end
    for (int unsigned i = 0; i < DW; i++) begin
      if (!found && weight(syn ^ GolayB[i]) <= 4'd2) begin
        found = 1'b1;
        err_d = unit_vec(i);
        err_p = syn ^ GolayB[i];
      end
    end
    if (!found && weight(tsyn) <= 4'd3) begin
      found = 1'b1;
      err_d = tsyn;
    end
    for (int unsigned i = 0; i < DW; i++) begin
      if (!found && weight(tsyn ^ GolayB[i]) <= 4'd2) begin
        found = 1'b1;
        err_d = tsyn ^ GolayB[i];
        err_p = unit_vec(i);
      end
    end
    // Detect-only mode and uncorrectable words both pass the raw word.
    dec.good   = (syn == '0);
    dec.bad    = !found;
    dec.data   = (mode_q && found) ? (data_q ^ err_d) : data_q;
    dec.parity = (mode_q && found) ? (par_q ^ err_p) : par_q;
  end

  always_comb begin
    data_d   = data_i;
    par_d    = parity_i;
    mode_d   = mode_i;
    vld_d    = {vld_q[LAT-2:0], valid_i};
    res_d[0] = dec;
    for (int unsigned k = 1; k < LAT-1; k++) res_d[k] = res_q[k-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      par_q  <= '0;
      mode_q <= 1'b0;
      vld_q  <= '0;
      for (int unsigned k = 0; k < LAT-1; k++) res_q[k] <= '0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
      mode_q <= mode_d;
      vld_q  <= vld_d;
      for (int unsigned k = 0; k < LAT-1; k++) res_q[k] <= res_d[k];
    end
  end

  assign vld_o = vld_q;
  assign res_o = res_q[LAT-2];

endmodule

// File: rtl/golay_stream_decoder.sv
// Multi-lane Golay(24,12) stream decoder: lane pipelines feed a credit-managed
// first-word-fall-through FIFO; saturating correction statistics are kept at write time.
module golay_stream_decoder
  import golay_pkg::*;
#(
  parameter int unsigned NLANES     = 1,
  parameter int unsigned LAT        = 5,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CORRECT_EN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [DW*NLANES-1:0] IN_DATA,
  input  logic [DW*NLANES-1:0] IN_PARITY,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DW*NLANES-1:0] OUT_DATA,
  output logic [DW*NLANES-1:0] OUT_PARITY,
  output logic [NLANES-1:0]    OUT_GOOD,
  output logic [NLANES-1:0]    OUT_BAD,
  input  logic                 CNT_CLR,
  output logic [CNT_W-1:0]     CORR_CNT,
  output logic [CNT_W-1:0]     UNCORR_CNT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = 2*DW*NLANES + 2*NLANES;
  localparam logic [AW:0] DepthW = FIFO_DEPTH[AW:0];

  logic [LAT-1:0] lane_vld [NLANES];
  lane_res_t      lane_res [NLANES];
  logic           accept, push, pop;
  logic [LAT-1:0] vld_all;
  logic [AW:0]    inflight;
  logic [FW-1:0]  push_word, head_word;
  logic [DW*NLANES-1:0] push_data, push_par;
  logic [NLANES-1:0]    push_good, push_bad;
  logic [CNT_W:0] n_corr, n_bad, corr_sum, bad_sum;

  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           rdy_en_q, rdy_en_d;
  logic [CNT_W-1:0] corr_q, corr_d, unc_q, unc_d;
  logic [FW-1:0]  mem_q [FIFO_DEPTH];

  assign accept = IN_VALID & IN_READY;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    golay_lane_dec #(
      .LAT(LAT)
    ) u_lane (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .valid_i (accept),
      .mode_i  (CORRECT_EN),
      .data_i  (IN_DATA[DW*k +: DW]),
      .parity_i(IN_PARITY[DW*k +: DW]),
      .vld_o   (lane_vld[k]),
      .res_o   (lane_res[k])
    );
  end

  always_comb begin
    vld_all   = '1;
    inflight  = '0;
    n_corr    = '0;
    n_bad     = '0;
    push_data = '0;
    push_par  = '0;
    push_good = '0;
    push_bad  = '0;
    for (int unsigned k = 0; k < NLANES; k++) vld_all = vld_all & lane_vld[k];
    for (int unsigned s = 0; s < LAT; s++) begin
      if (vld_all[s]) inflight = inflight + 1'b1;
    end
    for (int unsigned k = 0; k < NLANES; k++) begin
      push_data[DW*k +: DW] = lane_res[k].data;
      push_par[DW*k +: DW]  = lane_res[k].parity;
      push_good[k]          = lane_res[k].good;
      push_bad[k]           = lane_res[k].bad;
      if (!lane_res[k].good && !lane_res[k].bad) n_corr = n_corr + 1'b1;
      if (lane_res[k].bad) n_bad = n_bad + 1'b1;
    end
  end

  assign push      = vld_all[LAT-1];
  assign push_word = {push_data, push_par, push_good, push_bad};
  assign OUT_VALID = (cnt_q != '0);
  assign pop       = OUT_VALID & OUT_READY;
  // Credits cover both buffered and in-flight beats, so a push never finds the FIFO full.
  assign IN_READY  = rdy_en_q && ((cnt_q + inflight) < DepthW);

  always_comb begin
    wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d    = cnt_q;
    rdy_en_d = 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (!push && pop) cnt_d = cnt_q - 1'b1;
    corr_sum = {1'b0, corr_q} + n_corr;
    bad_sum  = {1'b0, unc_q} + n_bad;
    corr_d   = corr_q;
    unc_d    = unc_q;
    if (CNT_CLR) begin
      corr_d = '0;
      unc_d  = '0;
    end else if (push) begin
      corr_d = corr_sum[CNT_W] ? '1 : corr_sum[CNT_W-1:0];
      unc_d  = bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
      corr_q   <= '0;
      unc_q    <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= rdy_en_d;
      corr_q   <= corr_d;
      unc_q    <= unc_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= push_word;
  end

  assign head_word = OUT_VALID ? mem_q[rptr_q] : '0;
  assign {OUT_DATA, OUT_PARITY, OUT_GOOD, OUT_BAD} = head_word;
  assign CORR_CNT   = corr_q;
  assign UNCORR_CNT = unc_q;

endmodule

// File: tb/tb_golay_stream_decoder.sv
// Scoreboard bench: expected beats come from a nearest-codeword search over the whole
// code and are popped by an independent output monitor.
module tb_golay_stream_decoder;

  localparam int unsigned NL    = 2;
  localparam int unsigned LAT   = 5;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNTW  = 4;

  logic            CLK = 1'b0;
  logic            RST_N, CORRECT_EN, IN_VALID, IN_READY, OUT_VALID, OUT_READY, CNT_CLR;
  logic [12*NL-1:0] IN_DATA, IN_PARITY, OUT_DATA, OUT_PARITY;
  logic [NL-1:0]   OUT_GOOD, OUT_BAD;
  logic [CNTW-1:0] CORR_CNT, UNCORR_CNT;

  always #5 CLK = ~CLK;

  golay_stream_decoder #(
    .NLANES(NL), .LAT(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CNTW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CORRECT_EN(CORRECT_EN), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_PARITY(IN_PARITY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_PARITY(OUT_PARITY), .OUT_GOOD(OUT_GOOD), .OUT_BAD(OUT_BAD),
    .CNT_CLR(CNT_CLR), .CORR_CNT(CORR_CNT), .UNCORR_CNT(UNCORR_CNT)
  );

  logic [11:0] tb_b [12] = '{12'hDC5, 12'hB8B, 12'h717, 12'hE2D, 12'hC5B, 12'h8B7,
                             12'h16F, 12'h2DD, 12'h5B9, 12'hB71, 12'h6E3, 12'hFFE};
  logic [23:0] cw_tbl [4096];

  typedef struct {
    logic [23:0] d;
    logic [23:0] p;
    logic [1:0]  g;
    logic [1:0]  b;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   total = 0;
  int   errs = 0;
  int   exp_corr = 0;
  int   exp_unc = 0;
  int   acc_cnt;
  bit   acc;
  logic [23:0] w0, w1, din, pin;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    total++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic logic [11:0] enc(input logic [11:0] d);
    logic [11:0] p = '0;
    for (int i = 0; i < 12; i++) if (d[11-i]) p = p ^ tb_b[i];
    return p;
  endfunction

  function automatic logic [23:0] cw(input logic [11:0] d);
    return {d, enc(d)};
  endfunction

  function automatic logic [23:0] flip(input logic [23:0] w, input int n);
    logic [23:0] m = '0;
    int c = 0;
    while (c < n) begin
      int pos = $urandom_range(0, 23);
      if (!m[pos]) begin
        m[pos] = 1'b1;
        c++;
      end
    end
    return w ^ m;
  endfunction

  // Nearest codeword by exhaustive search; distance 4 means uncorrectable.
  task automatic model_lane(input logic [23:0] rx, input logic mode, output logic [23:0] o,
                            output logic g, output logic b);
    int best = 99;
    logic [23:0] bc = '0;
    for (int c = 0; c < 4096; c++) begin
      int dd = $countones(rx ^ cw_tbl[c]);
      if (dd < best) begin
        best = dd;
        bc = cw_tbl[c];
      end
    end
    g = (best == 0);
    b = (best >= 4);
    o = (mode && !b) ? bc : rx;
  endtask

  task automatic push_exp(input logic [23:0] dv, input logic [23:0] pv, input logic mode);
    exp_t e;
    logic [23:0] o;
    logic g, b;
    for (int k = 0; k < 2; k++) begin
      model_lane({dv[12*k +: 12], pv[12*k +: 12]}, mode, o, g, b);
      e.d[12*k +: 12] = o[23:12];
      e.p[12*k +: 12] = o[11:0];
      e.g[k] = g;
      e.b[k] = b;
      if (!g && !b) exp_corr = (exp_corr >= 15) ? 15 : exp_corr + 1;
      if (b) exp_unc = (exp_unc >= 15) ? 15 : exp_unc + 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic pack(input logic [23:0] a, input logic [23:0] b, output logic [23:0] dv,
                      output logic [23:0] pv);
    dv = {b[23:12], a[23:12]};
    pv = {b[11:0], a[11:0]};
  endtask

  // Offers one beat for one cycle; called and returns at posedge+1.
  task automatic drive_beat(input logic [23:0] dv, input logic [23:0] pv, input logic mode,
                            output bit ok);
    IN_DATA = dv;
    IN_PARITY = pv;
    CORRECT_EN = mode;
    IN_VALID = 1'b1;
    ok = IN_READY;
    if (ok) push_exp(dv, pv, mode);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic send(input logic [23:0] dv, input logic [23:0] pv, input logic mode);
    bit ok = 0;
    int n = 0;
    while (!ok && n < 200) begin
      drive_beat(dv, pv, mode, ok);
      n++;
    end
    if (!ok) begin
      total++;
      errs++;
      $display("FAIL send_timeout: got IN_READY=0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    OUT_READY = 1'b1;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_corr"}, 64'(CORR_CNT), 64'(exp_corr));
    check({tag, "_uncorr"}, 64'(UNCORR_CNT), 64'(exp_unc));
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          errs++;
          $display("FAIL unexpected_out: got beat %h, required none", OUT_DATA);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_beat", 64'({OUT_DATA, OUT_PARITY, OUT_GOOD, OUT_BAD}),
                64'({mon_e.d, mon_e.p, mon_e.g, mon_e.b}));
        end
      end else if (!OUT_VALID) begin
        check("idle_zero", 64'({OUT_DATA, OUT_PARITY, OUT_GOOD, OUT_BAD}), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 4096; d++) cw_tbl[d] = cw(12'(d));
    RST_N = 1'b0;
    CORRECT_EN = 1'b1;
    IN_VALID = 1'b0;
    IN_DATA = '0;
    IN_PARITY = '0;
    OUT_READY = 1'b1;
    CNT_CLR = 1'b0;
    #12;
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_in_ready", 64'(IN_READY), 64'd0);
    check("rst_counts", 64'({CORR_CNT, UNCORR_CNT}), 64'd0);
    check("rst_out_data", 64'({OUT_DATA, OUT_GOOD, OUT_BAD}), 64'd0);
    #20 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("ready_after_rst", 64'(IN_READY), 64'd1);

    // Zero codeword, with latency of the first-word-fall-through head.
    send(24'h0, 24'h0, 1'b1);
    repeat (LAT-1) @(posedge CLK);
    #1;
    check("lat_early", 64'(OUT_VALID), 64'd0);
    @(posedge CLK);
    #1;
    check("lat_first", 64'(OUT_VALID), 64'd1);
    check("lat_good", 64'(OUT_GOOD), 64'd3);
    drain();
    check_cnts("zero");

    // Three data errors on lane 0.
    w0 = cw(12'hA5C) ^ 24'h821000;
    w1 = cw(12'($urandom));
    pack(w0, w1, din, pin);
    send(din, pin, 1'b1);
    drain();
    check_cnts("three_err");

    // Four parity errors on lane 1, then a single error in detect-only mode.
    w0 = cw(12'($urandom));
    w1 = cw(12'($urandom)) ^ 24'h00000F;
    pack(w0, w1, din, pin);
    send(din, pin, 1'b1);
    drain();
    check_cnts("four_err");
    w0 = cw(12'($urandom)) ^ 24'h001000;
    w1 = cw(12'($urandom));
    pack(w0, w1, din, pin);
    send(din, pin, 1'b0);
    drain();
    check_cnts("detect_only");

    // Random traffic: 0..4 errors per lane, random mode and consumer stalls.
    for (int i = 0; i < 150; i++) begin
      OUT_READY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        w0 = flip(cw(12'($urandom)), $urandom_range(0, 4));
        w1 = flip(cw(12'($urandom)), $urandom_range(0, 4));
        pack(w0, w1, din, pin);
        drive_beat(din, pin, ($urandom_range(0, 4) != 0), acc);
      end else begin
        @(posedge CLK);
        #1;
      end
    end
    drain();
    check_cnts("random");

    // Backpressure: consumer stalled while the producer streams.
    OUT_READY = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      w0 = flip(cw(12'($urandom)), $urandom_range(0, 3));
      w1 = cw(12'($urandom));
      pack(w0, w1, din, pin);
      drive_beat(din, pin, 1'b1, acc);
      if (acc) acc_cnt++;
    end
    check("bp_accepted", 64'(acc_cnt), 64'(DEPTH));
    check("bp_in_ready", 64'(IN_READY), 64'd0);
    drain();

    // Saturation and clear coincident with a counted write.
    CNT_CLR = 1'b1;
    @(posedge CLK);
    #1;
    CNT_CLR = 1'b0;
    exp_corr = 0;
    exp_unc = 0;
    check_cnts("clear");
    for (int i = 0; i < 20; i++) begin
      pack(flip(cw(12'($urandom)), 1), cw(12'($urandom)), din, pin);
      send(din, pin, 1'b1);
    end
    drain();
    check_cnts("saturate");
    CNT_CLR = 1'b1;
    @(posedge CLK);
    #1;
    CNT_CLR = 1'b0;
    pack(flip(cw(12'($urandom)), 2), cw(12'($urandom)), din, pin);
    send(din, pin, 1'b1);
    repeat (LAT-1) @(posedge CLK);
    #1;
    CNT_CLR = 1'b1;
    @(posedge CLK);
    #1;
    CNT_CLR = 1'b0;
    exp_corr = 0;
    exp_unc = 0;
    drain();
    check_cnts("clr_coincident");

    // Reset with two beats buffered and three in flight.
    OUT_READY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pack(flip(cw(12'($urandom)), 1), flip(cw(12'($urandom)), 4), din, pin);
      send(din, pin, 1'b1);
    end
    repeat (LAT+1) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      pack(flip(cw(12'($urandom)), 3), cw(12'($urandom)), din, pin);
      send(din, pin, 1'b1);
    end
    RST_N = 1'b0;
    #1;
    check("midrst_out_valid", 64'(OUT_VALID), 64'd0);
    check("midrst_in_ready", 64'(IN_READY), 64'd0);
    exp_q.delete();
    exp_corr = 0;
    exp_unc = 0;
    @(posedge CLK);
    #2 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_ready", 64'(IN_READY), 64'd1);
    OUT_READY = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    check("midrst_empty", 64'(OUT_VALID), 64'd0);
    check_cnts("midrst");
    pack(flip(cw(12'($urandom)), 1), cw(12'($urandom)), din, pin);
    send(din, pin, 1'b1);
    drain();
    check_cnts("post_rst");

    $display("test done: total=%0d bad=%0d", total, errs);
    $finish;
  end

endmodule

// File: doc/golay_stream_decoder.md
Name: golay_stream_decoder

Overview:
- Multi-lane, flow-controlled Golay(24,12) decoder for PROM/config readback streams.
- Each beat carries NLANES codewords (12 data + 12 parity). Each codeword is corrected (up to 3 bit errors) or flagged uncorrectable (4 errors).
- Decoded words pass through an internal credit-managed output FIFO. Running error statistics are kept.
- Sits between the PROM reader and the configuration loader, replacing the fixed single-word, no-handshake decoder.

Parameters:
- NLANES, 1, codewords per beat.
- LAT, 5, lane decode pipeline latency in cycles (>=2).
- FIFO_DEPTH, 8, output FIFO entries; power of 2, >= LAT+2.
- CNT_W, 16, width of the statistics counters.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CORRECT_EN  in  1  1 = correct; 0 = detect only, raw data passed.
- IN_VALID  in  1  beat valid.
- IN_READY  out  1  beat accepted when IN_VALID & IN_READY.
- IN_DATA  in  12*NLANES  received data, lane k at [12k+11:12k].
- IN_PARITY  in  12*NLANES  received parity, same lane packing.
- OUT_VALID  out  1  FIFO head valid.
- OUT_READY  in  1  consumer pops when OUT_VALID & OUT_READY.
- OUT_DATA  out  12*NLANES  decoded data.
- OUT_PARITY  out  12*NLANES  decoded parity.
- OUT_GOOD  out  NLANES  lane syndrome was zero.
- OUT_BAD  out  NLANES  lane uncorrectable.
- CNT_CLR  in  1  synchronous clear of both counters.
- CORR_CNT  out  CNT_W  codewords corrected, saturating.
- UNCORR_CNT  out  CNT_W  codewords uncorrectable, saturating.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Pipeline valids, FIFO pointers/count and counters go to 0.
  - OUT_VALID=0, IN_READY=0 while in reset; IN_READY=1 from the first clock edge after release.
  - OUT_DATA/OUT_PARITY/flags are 0 while OUT_VALID=0.
  - Reset mid-stream discards all in-flight and buffered beats; nothing partial emerges.
- Code definition: generator [I | B], with B the standard 12x12 extended-Golay matrix.
  - Syndrome s = p XOR (d·B).
  - w(s)<=3: e = (0, s).
  - Else, for some i, w(s XOR b_i)<=2: e = (u_i, s XOR b_i).
  - Else t = s·B. If w(t)<=3: e = (t, 0). Else, for some i, w(t XOR b_i)<=2: e = (t XOR b_i, u_i).
  - Else: uncorrectable.
  - b_i is row i of B; u_i is the unit vector; w is Hamming weight.
- Per lane:
  - GOOD = (s==0).
  - BAD = no pattern found.
  - Corrected = !GOOD & !BAD.
  - Output = received XOR e if CORRECT_EN & !BAD; otherwise the raw received word. BAD is always reported, including in detect-only mode.
- Latency: a beat accepted at edge n is written to the FIFO at edge n+LAT. With an empty FIFO, OUT_VALID rises after edge n+LAT, so the head is visible first-word-fall-through.
- Pipeline: a valid bit shifts alongside the data; the pipeline never stalls.
- Credit flow control: IN_READY = (fifo_count + inflight) < FIFO_DEPTH, where inflight = number of valid pipeline stages. The FIFO therefore can never overflow.
  - A pop in the same cycle frees its credit next cycle, not combinationally.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Order is preserved end-to-end. Lanes within a beat are independent.
- Counters update at FIFO write time, beat granularity:
  - CORR_CNT increases by the number of corrected lanes; UNCORR_CNT by the number of BAD lanes.
  - Both saturate at all-ones.
  - CNT_CLR wins over a simultaneous increment: result is 0.
  - CNT_CLR does not affect data flow.
- CORRECT_EN is sampled at acceptance and carried down the pipeline. Changing it mid-stream affects only later beats.

Decomposition:
- Package golay_pkg:
  - B matrix constant.
  - Weight function.
  - Lane slice widths (DW=12, CW=24).
  - Lane result struct {data, parity, good, bad}.
- Sub-module golay_lane_dec (parameter LAT): one lane's pipelined syndrome, weight tests and correction, plus valid/mode sideband. Instantiated NLANES times via generate.
- Top level: credit logic, FIFO and counters.

Test Plan:
- Zero codeword: NLANES=2, all lanes d=0x000 p=0x000, OUT_READY=1 → after LAT cycles OUT_DATA=0, OUT_GOOD=2'b11, OUT_BAD=0, counters stay 0.
- Three errors: lane0 = model-encoded 0xA5C with data bits 0,5,11 flipped → OUT_DATA lane0=0xA5C, GOOD=0, BAD=0, CORR_CNT=1.
- Four errors: lane1 with 4 parity bits flipped → OUT_BAD[1]=1, raw word out, UNCORR_CNT=1. Repeat with CORRECT_EN=0 and a 1-bit error → raw data out, BAD=0, CORR_CNT still increments.
- Backpressure: continuous IN_VALID, OUT_READY=0 for 20 cycles → exactly FIFO_DEPTH beats accepted, then IN_READY=0. Release → all beats emerge in order, none lost or duplicated.
- Counter saturation: CNT_W=4, 20 corrected beats → CORR_CNT=15. CNT_CLR coincident with a corrected beat → CORR_CNT=0.
- Reset mid-stream: RST_N low for 1 cycle with 3 beats in flight and 2 buffered → OUT_VALID=0 immediately; after release, nothing pre-reset emerges and counters are 0.
